// File: rtl/mult4s_product_accumulator_if.sv
// Handshake bundle between a product source and the product accumulator.
// The slave modport is the accumulator's view; master is the source/consumer side.
interface mult4s_product_accumulator_if #(
    parameter int ACC_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_product;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_overflow;

    modport master (
        output in_valid, in_product, out_ready,
        input  in_ready, out_valid, out_sum, out_overflow
    );

    modport slave (
        input  in_valid, in_product, out_ready,
        output in_ready, out_valid, out_sum, out_overflow
    );
endinterface

// File: rtl/mult4s_product_accumulator.sv
// Sums N_TERMS signed 8-bit products per result and presents each sum on a valid/ready port.
// Define MULT_ACC_SAT_EN to saturate on overflow instead of wrapping.
module mult4s_product_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mult4s_product_accumulator_if.slave  bus
);
    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

    typedef enum logic {
        ST_ACCUM,
        ST_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
`ifdef MULT_ACC_SAT_EN
    logic [ACC_W-1:0] sat;
`endif

    always_comb begin
        ext      = {ACC_W{bus.in_product[7]}};
        ext[7:0] = bus.in_product;
        sum      = acc_q + ext;
        add_ovf  = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef MULT_ACC_SAT_EN
        // Overflow direction follows the shared operand sign.
        sat      = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_ACCUM: begin
                if (bus.in_valid) begin
                    if (cnt_q == '0) begin
                        acc_d = ext;
                    end else if (add_ovf) begin
                        ovf_d = 1'b1;
`ifdef MULT_ACC_SAT_EN
                        acc_d = sat;
`else
                        acc_d = sum;
`endif
                    end else begin
                        acc_d = sum;
                    end
                    if (cnt_q == LAST_TERM) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                // Accumulator is left as-is; the next term 0 reloads it.
                if (bus.out_ready) begin
                    state_d = ST_ACCUM;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready     = (state_q == ST_ACCUM);
    assign bus.out_valid    = (state_q == ST_HOLD);
    assign bus.out_sum      = acc_q;
    assign bus.out_overflow = ovf_q;
endmodule

// File: tb/tb_mult4s_product_accumulator.sv
// Directed self-checking bench for mult4s_product_accumulator in three configurations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mult4s_product_accumulator;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mult4s_product_accumulator_if #(.ACC_W(12)) if0 ();
    mult4s_product_accumulator_if #(.ACC_W(8))  if1 ();
    mult4s_product_accumulator_if #(.ACC_W(12)) if2 ();

    mult4s_product_accumulator #(.N_TERMS(4), .ACC_W(12)) u_dflt (.clk(clk), .rst_n(rst_n), .bus(if0));
    mult4s_product_accumulator #(.N_TERMS(2), .ACC_W(8))  u_narrow (.clk(clk), .rst_n(rst_n), .bus(if1));
    mult4s_product_accumulator #(.N_TERMS(1), .ACC_W(12)) u_single (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one term per clock and leave in_valid low afterwards.
    task automatic feed0(input int p);
        if0.in_valid   = 1'b1;
        if0.in_product = 8'(p);
        @(negedge clk);
        if0.in_valid   = 1'b0;
    endtask

    task automatic feed1(input int p);
        if1.in_valid   = 1'b1;
        if1.in_product = 8'(p);
        @(negedge clk);
        if1.in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid0: got %b expected 0", if0.out_valid); end
        n_checks++; if (if0.out_sum !== 12'h000) begin n_fail++; $display("[TB] FAIL reset_out_sum0: got %h expected 000", if0.out_sum); end
        n_checks++; if (if0.out_overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf0: got %b expected 0", if0.out_overflow); end
        n_checks++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready0: got %b expected 1", if0.in_ready); end
        n_checks++; if (if1.out_valid !== 1'b0 || if1.out_sum !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_narrow: got valid=%b sum=%h expected 0/00", if1.out_valid, if1.out_sum); end
        n_checks++; if (if2.out_valid !== 1'b0 || if2.out_sum !== 12'h000) begin n_fail++; $display("[TB] FAIL reset_single: got valid=%b sum=%h expected 0/000", if2.out_valid, if2.out_sum); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_sum();
        int p[4] = '{10, 20, -5, 7};
        if0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_in_ready term %0d: got %b expected 1", i, if0.in_ready); end
            feed0(p[i]);
        end
        n_checks++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_out_valid: got %b expected 1", if0.out_valid); end
        n_checks++; if (if0.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_hold_in_ready: got %b expected 0", if0.in_ready); end
        n_checks++; if (if0.out_sum !== 12'h020) begin n_fail++; $display("[TB] FAIL basic_sum: got %h expected 020", if0.out_sum); end
        n_checks++; if (if0.out_overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_ovf: got %b expected 0", if0.out_overflow); end
        @(negedge clk);
        n_checks++; if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_release: got ready=%b valid=%b expected 1/0", if0.in_ready, if0.out_valid); end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < 4; i++) feed0(64);
        n_checks++; if (if0.out_sum !== 12'h100 || if0.out_overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL extreme_pos: got %h ovf=%b expected 100 ovf=0", if0.out_sum, if0.out_overflow); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) feed0(-56);
        n_checks++; if (if0.out_sum !== 12'hF20 || if0.out_overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL extreme_neg: got %h ovf=%b expected F20 ovf=0", if0.out_sum, if0.out_overflow); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [7:0] exp_ovf_sum;
`ifdef MULT_ACC_SAT_EN
        exp_ovf_sum = 8'h7F;
`else
        exp_ovf_sum = 8'h80;
`endif
        if1.out_ready = 1'b1;
        feed1(64);
        feed1(64);
        n_checks++; if (if1.out_valid !== 1'b1 || if1.out_sum !== exp_ovf_sum) begin n_fail++; $display("[TB] FAIL ovf_sum: got valid=%b sum=%h expected 1/%h", if1.out_valid, if1.out_sum, exp_ovf_sum); end
        n_checks++; if (if1.out_overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_flag: got %b expected 1", if1.out_overflow); end
        @(negedge clk);
        feed1(1);
        feed1(2);
        n_checks++; if (if1.out_sum !== 8'h03) begin n_fail++; $display("[TB] FAIL ovf_next_sum: got %h expected 03", if1.out_sum); end
        n_checks++; if (if1.out_overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_cleared: got %b expected 0", if1.out_overflow); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        if0.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) feed0(i);
        for (int i = 0; i < 5; i++) begin
            if0.in_valid   = 1'b1;
            if0.in_product = 8'(50 + i);
            @(negedge clk);
            n_checks++; if (if0.out_sum !== 12'h00A || if0.in_ready !== 1'b0 || if0.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_stall cycle %0d: got sum=%h ready=%b valid=%b expected 00A/0/1", i, if0.out_sum, if0.in_ready, if0.out_valid); end
        end
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release: got %b expected 1", if0.in_ready); end
        for (int i = 0; i < 4; i++) feed0(2);
        n_checks++; if (if0.out_valid !== 1'b1 || if0.out_sum !== 12'h008) begin n_fail++; $display("[TB] FAIL bp_next_term0: got valid=%b sum=%h expected 1/008", if0.out_valid, if0.out_sum); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        feed0(3);
        feed0(4);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (if0.out_valid !== 1'b0 || if0.out_sum !== 12'h000 || if0.out_overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_outputs: got valid=%b sum=%h ovf=%b expected 0/000/0", if0.out_valid, if0.out_sum, if0.out_overflow); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            feed0(1);
            n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_early_valid term %0d: got %b expected 0", i, if0.out_valid); end
        end
        feed0(1);
        n_checks++; if (if0.out_valid !== 1'b1 || if0.out_sum !== 12'h004) begin n_fail++; $display("[TB] FAIL midrst_sum: got valid=%b sum=%h expected 1/004", if0.out_valid, if0.out_sum); end
        @(negedge clk);
    endtask

    task automatic test_stalled_input();
        logic pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic exp_hold;
        int   accepts;
        for (int i = 0; i < 7; i++) begin
            if0.in_valid   = pat[i];
            if0.in_product = 8'd5;
            @(negedge clk);
        end
        if0.in_valid = 1'b0;
        n_checks++; if (if0.out_valid !== 1'b1 || if0.out_sum !== 12'h014) begin n_fail++; $display("[TB] FAIL stall_sum: got valid=%b sum=%h expected 1/014", if0.out_valid, if0.out_sum); end
        @(negedge clk);

        // Single-term build: HOLD lasts one cycle, so a valid during HOLD is skipped.
        if2.out_ready = 1'b1;
        exp_hold = 1'b0;
        accepts  = 0;
        for (int i = 0; i < 7; i++) begin
            if2.in_valid   = pat[i];
            if2.in_product = 8'hFF;
            if (!exp_hold && pat[i]) accepts++;
            exp_hold = !exp_hold && pat[i];
            @(negedge clk);
            n_checks++; if (if2.out_valid !== exp_hold) begin n_fail++; $display("[TB] FAIL single_valid cycle %0d: got %b expected %b", i, if2.out_valid, exp_hold); end
            if (exp_hold) begin
                n_checks++; if (if2.out_sum !== 12'hFFF) begin n_fail++; $display("[TB] FAIL single_sum cycle %0d: got %h expected FFF", i, if2.out_sum); end
            end
        end
        if2.in_valid = 1'b0;
        n_checks++; if (accepts != 3) begin n_fail++; $display("[TB] FAIL single_accepts: got %0d expected 3", accepts); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        if0.out_ready  = 1'b1;
        if0.in_valid   = 1'b1;
        if0.in_product = 8'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (if0.out_valid !== ((i % 5) == 3)) begin n_fail++; $display("[TB] FAIL b2b_valid cycle %0d: got %b expected %b", i, if0.out_valid, ((i % 5) == 3)); end
            if ((i % 5) == 3) begin
                n_checks++; if (if0.out_sum !== 12'h004) begin n_fail++; $display("[TB] FAIL b2b_sum cycle %0d: got %h expected 004", i, if0.out_sum); end
            end
        end
        if0.in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        if0.in_valid = 1'b0; if0.in_product = 8'h00; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.in_product = 8'h00; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.in_product = 8'h00; if2.out_ready = 1'b1;
        test_reset();
        test_basic_sum();
        test_extremes();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_stalled_input();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mult4s_product_accumulator.md
# mult4s_product_accumulator

Downstream consumer of the registered 8-bit signed product from the 4-bit signed multiplier wrapper. Accepts one product per valid/ready handshake and sums a fixed number of products (N_TERMS) into a wider signed accumulator. Presents each completed sum on a valid/ready output port. Gives the multiplier characterisation flow a dot-product / MAC datapath for timing and area runs.

## Interface
- `N_TERMS`, default 4: products summed per result; legal range ≥ 1.
- `ACC_W`, default 12: accumulator and result width in bits; legal range ≥ 8.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: `in_product` is valid this cycle.
- `in_ready` out 1: block can accept a product this cycle.
- `in_product` in 8: two's-complement product; legal operand range gives −56..64.
- `out_valid` out 1: `out_sum` and `out_overflow` hold a completed result.
- `out_ready` in 1: consumer accepts the result this cycle.
- `out_sum` out ACC_W: two's-complement sum of N_TERMS products.
- `out_overflow` out 1: at least one addition in this result overflowed ACC_W.

## Operation
- Input accept: `in_valid && in_ready`. Output accept: `out_valid && out_ready`.
- Two states:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Reset (`rst_n`=0 at a clock edge):
  - state goes to ACCUM; accumulator, term counter (clog2 of N_TERMS bits, minimum 1) and overflow flag clear to 0.
  - `out_sum`=0, `out_overflow`=0, `out_valid`=0.
  - reset overrides every concurrent event.
- ACCUM, on input accept:
  - `in_product` is sign-extended to ACC_W.
  - If the counter is 0, the accumulator loads the extended product (no add, no overflow possible).
  - Otherwise the accumulator loads accumulator + extended product.
  - Overflow means both operands have the same sign and the result sign differs; it sets the sticky overflow flag.
- When the accepted term is number N_TERMS−1: counter wraps to 0 and the state goes to HOLD. Otherwise the counter increments.
- ACCUM with no accept: all state holds.
- HOLD:
  - `out_sum` = accumulator; `out_overflow` = sticky flag.
  - On output accept: go to ACCUM and clear the flag. The accumulator value is don't-care because the next first term reloads it.
  - While `out_ready`=0, `out_sum` and `out_overflow` stay stable.
- `in_product` is ignored whenever `in_ready`=0. Inputs asserted during HOLD are not consumed.
- N_TERMS=1: every accepted product goes directly to HOLD.
- `in_ready` and `out_valid` are decoded from registered state only. There are no combinational paths from inputs to outputs.

## Timing
- `out_valid` rises in the cycle after the accept of the last term.
- Earliest next input accept is the cycle after the output accept. This gives one bubble per result.
- Throughput: one result per N_TERMS+1 cycles when `in_valid` and `out_ready` stay high.
- Reset mid-accumulation discards the partial sum. The first accept after reset is term 0.

## Configuration
- `MULT_ACC_SAT_EN` defined:
  - On an overflowing add, the accumulator saturates to +2^(ACC_W−1)−1 (positive overflow) or −2^(ACC_W−1) (negative overflow).
  - Later adds continue from the saturated value.
  - `out_overflow` is still set.
- `MULT_ACC_SAT_EN` undefined: two's-complement wrap; `out_overflow` still set.
- No other behaviour differs between the two builds.

## Test plan
- Basic sum: defaults, `out_ready`=1; drive 10, 20, −5, 7 on consecutive cycles.
  - Required: `out_valid` high 1 cycle after the 7 is accepted; `out_sum`=12'h020, `out_overflow`=0.
  - Required: `in_ready`=0 only during the HOLD cycle.
- Extremes: defaults, four products of 64.
  - Required: `out_sum`=12'h100, no overflow.
  - Then four products of −56: required `out_sum`=12'hF20 (−224), no overflow.
- Overflow: ACC_W=8, N_TERMS=2; products 64, 64.
  - Without macro: `out_sum`=8'h80, `out_overflow`=1.
  - With `MULT_ACC_SAT_EN`: `out_sum`=8'h7F, `out_overflow`=1.
  - Next result 1, 2: required 8'h03, `out_overflow`=0 (flag cleared).
- Backpressure: complete a result, then hold `out_ready`=0 for 5 cycles while `in_valid`=1 with changing `in_product`.
  - Required: `out_sum` stable, `in_ready`=0, no product consumed.
  - Required: after `out_ready` pulses, the next accepted input is term 0.
- Reset mid-operation: accept 3, 4 (defaults), then assert `rst_n`=0 for 1 cycle, then accept 1, 1, 1, 1.
  - Required: all outputs 0 during reset; final `out_sum`=12'h004.
- Stalled input: `in_valid` toggling 1,0,0,1,1,0,1 with products 5 each.
  - Required: `out_sum`=12'h014 after the 4th accept.
  - Repeat with N_TERMS=1, product −1: every accept yields `out_sum`=12'hFFF.
